// File: rtl/tt_capture.sv
// Truth-table capture engine: sweeps a 7-input vector through all 128 values,
// holds each vector for SETTLE+1 cycles, samples the single-bit response on the
// last cycle of each hold and presents the 128-bit table plus its popcount
// through a valid/ready handshake.
module tt_capture #(
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         x0,
  output logic         x1,
  output logic         x2,
  output logic         x3,
  output logic         x4,
  output logic         x5,
  output logic         x6,
  input  logic         f_in,
  output logic         busy,
  output logic [127:0] tt,
  output logic [7:0]   ones,
  output logic         tt_valid,
  input  logic         tt_ready
);

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  state_e       state_q, state_d;
  logic [6:0]   idx_q, idx_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] tt_q, tt_d;
  logic [7:0]   ones_q, ones_d;
  logic [6:0]   vec;

  // Next-state and datapath update; the sample edge is the last cycle of a vector's hold.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCapture;
          idx_d   = 7'd0;
          cnt_d   = 4'd0;
          tt_d    = '0;
          ones_d  = 8'd0;
        end
      end
      StCapture: begin
        if (cnt_q == SettleCnt) begin
          tt_d[idx_q] = f_in;
          // 128 ones fit in 8 bits, so no saturation is needed.
          ones_d      = ones_q + {7'd0, f_in};
          if (idx_q == 7'd127) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 7'd1;
            cnt_d = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        if (tt_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 7'd0;
      cnt_q   <= 4'd0;
      tt_q    <= '0;
      ones_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  // Stimulus is only driven while capturing; otherwise the vector rests at zero.
  always_comb begin
    vec = (state_q == StCapture) ? idx_q : 7'd0;
  end

  assign {x6, x5, x4, x3, x2, x1, x0} = vec;
  assign busy     = (state_q == StCapture);
  assign tt_valid = (state_q == StDone);
  assign tt       = tt_q;
  assign ones     = ones_q;

endmodule

// File: tb/tb_tt_capture.sv
// Scoreboard bench for tt_capture: one instance with SETTLE=1 driven by simple
// combinational functions, one with SETTLE=3 driven by a 2-cycle delayed x0.
module tb_tt_capture;

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   ones;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n = 1'b0;
  logic         start_a = 1'b0, ready_a = 1'b0, start_b = 1'b0, ready_b = 1'b0;
  wire  [6:0]   xa, xb;
  logic         fa, fb, d1, d2;
  logic         busy_a, busy_b, valid_a, valid_b;
  logic [127:0] tt_a, tt_b;
  logic [7:0]   ones_a, ones_b;
  int           sel_a = 0;

  exp_t qa[$];
  exp_t qb[$];

  function automatic logic fsel(input int s, input logic [6:0] x);
    case (s)
      1:       return x[0];
      2:       return x[6];
      3:       return &x;
      4:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb fa = fsel(sel_a, xa);

  // Function under test for instance B: x0 seen through two register stages.
  always @(posedge clk) begin
    d1 <= xb[0];
    d2 <= d1;
  end
  assign fb = d2;

  tt_capture #(.SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .x4(xa[4]), .x5(xa[5]), .x6(xa[6]),
    .f_in(fa), .busy(busy_a), .tt(tt_a), .ones(ones_a), .tt_valid(valid_a), .tt_ready(ready_a)
  );

  tt_capture #(.SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .x4(xb[4]), .x5(xb[5]), .x6(xb[6]),
    .f_in(fb), .busy(busy_b), .tt(tt_b), .ones(ones_b), .tt_valid(valid_b), .tt_ready(ready_b)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitors: on each rising tt_valid, pop the expected table and compare.
  int   start_a_cyc = 0, start_b_cyc = 0;
  logic busy_a_p = 1'b0, valid_a_p = 1'b0, busy_b_p = 1'b0, valid_b_p = 1'b0;
  exp_t ea, eb;

  always @(negedge clk) begin
    if (busy_a && !busy_a_p) start_a_cyc = cyc;
    if (valid_a && !valid_a_p) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_valid: got tt_valid=1 want no result pending");
      end else begin
        ea = qa.pop_front();
        chk("a_tt", tt_a, ea.tt);
        chk("a_ones", 128'(ones_a), 128'(ea.ones));
        chk("a_latency", 128'(cyc - start_a_cyc), 128'(ea.lat));
      end
    end
    busy_a_p  = busy_a;
    valid_a_p = valid_a;
  end

  always @(negedge clk) begin
    if (busy_b && !busy_b_p) start_b_cyc = cyc;
    if (valid_b && !valid_b_p) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_valid: got tt_valid=1 want no result pending");
      end else begin
        eb = qb.pop_front();
        chk("b_tt", tt_b, eb.tt);
        chk("b_ones", 128'(ones_b), 128'(eb.ones));
        chk("b_latency", 128'(cyc - start_b_cyc), 128'(eb.lat));
      end
    end
    busy_b_p  = busy_b;
    valid_b_p = valid_b;
  end

  // Full capture on instance A, then hold DONE for `hold` cycles with start pulses.
  task automatic capture_a(input int s, input logic [127:0] et, input logic [7:0] eo,
                           input int hold);
    exp_t e;
    int   n;
    e.tt = et;
    e.ones = eo;
    e.lat = 256;
    qa.push_back(e);
    sel_a   = s;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_start", 128'(busy_a), 128'd1);
    n = 0;
    while (!valid_a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!valid_a) begin
      checks++;
      errors++;
      $display("FAIL a_timeout: got no tt_valid want tt_valid within 1000 cycles");
      return;
    end
    for (int k = 0; k < hold; k++) begin
      start_a = (k % 2 == 0);
      @(negedge clk);
      chk("a_hold_valid", 128'(valid_a), 128'd1);
      chk("a_hold_busy", 128'(busy_a), 128'd0);
      chk("a_hold_tt", tt_a, et);
      chk("a_hold_ones", 128'(ones_a), 128'(eo));
    end
    start_a = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ready_a = 1'b0;
    chk("a_valid_after_ready", 128'(valid_a), 128'd0);
    chk("a_busy_after_ready", 128'(busy_a), 128'd0);
    chk("a_idle_tt_kept", tt_a, et);
    chk("a_idle_ones_kept", 128'(ones_a), 128'(eo));
    @(negedge clk);
    chk("a_start_not_queued", 128'(busy_a), 128'd0);
  endtask

  logic [127:0] tt_alt, tt_x6, tt_and, tt_all;

  initial begin
    int n;
    exp_t e;
    tt_alt = {32{4'hA}};
    tt_x6  = {{64{1'b1}}, {64{1'b0}}};
    tt_and = {1'b1, 127'd0};
    tt_all = {128{1'b1}};

    // Reset with start and tt_ready asserted: reset must win.
    rst_n   = 1'b0;
    start_a = 1'b1;
    ready_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_x", 128'(xa), 128'd0);
    chk("rst_busy", 128'(busy_a), 128'd0);
    chk("rst_valid", 128'(valid_a), 128'd0);
    chk("rst_tt", tt_a, 128'd0);
    chk("rst_ones", 128'(ones_a), 128'd0);
    start_a = 1'b0;
    ready_a = 1'b0;
    rst_n   = 1'b1;

    // First edge after release accepts start.
    capture_a(0, 128'd0, 8'd0, 2);
    capture_a(1, tt_alt, 8'd64, 10);
    capture_a(2, tt_x6, 8'd64, 0);
    capture_a(3, tt_and, 8'd1, 1);
    capture_a(4, tt_all, 8'd128, 1);

    // Abort at vector 40: no result is expected from this run.
    sel_a   = 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (xa != 7'd40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_40", 128'(xa), 128'd40);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_x", 128'(xa), 128'd0);
    chk("abort_busy", 128'(busy_a), 128'd0);
    chk("abort_valid", 128'(valid_a), 128'd0);
    chk("abort_tt", tt_a, 128'd0);
    chk("abort_ones", 128'(ones_a), 128'd0);
    capture_a(1, tt_alt, 8'd64, 0);

    // SETTLE=3 with a 2-cycle-late function still captures correctly.
    e.tt = tt_alt;
    e.ones = 8'd64;
    e.lat = 512;
    qb.push_back(e);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!valid_b && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!valid_b) begin
      checks++;
      errors++;
      $display("FAIL b_timeout: got no tt_valid want tt_valid within 2000 cycles");
    end
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    chk("b_valid_after_ready", 128'(valid_b), 128'd0);
    chk("a_queue_drained", 128'(qa.size()), 128'd0);
    chk("b_queue_drained", 128'(qb.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_capture.md
TT_CAPTURE -- requirements
Module: tt_capture

Interface
REQ-001 Parameter SETTLE, default 1, range 1..15: extra cycles each input vector is held before f_in is sampled.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a full truth-table capture; honoured only in IDLE.
REQ-005 x0..x6  output  1 each  stimulus vector driven to the 7-input function under test.
REQ-006 f_in  input  1  single-bit response of the function under test (its out).
REQ-007 busy  output  1  high while in CAPTURE.
REQ-008 tt  output  128  captured truth table; tt[i] = f at vector i.
REQ-009 ones  output  8  number of 1 bits in tt, range 0..128.
REQ-010 tt_valid  output  1  tt/ones complete and held.
REQ-011 tt_ready  input  1  consumer accepts tt/ones.

Function
REQ-012 Vector index i is 7 bits, i = {x6,x5,x4,x3,x2,x1,x0}; x0 is the LSB.
REQ-013 The block SHALL have three states: IDLE, CAPTURE, DONE.
REQ-014 IDLE: x0..x6 = 0, busy = 0, tt_valid = 0; start = 1 -> CAPTURE, i = 0, wait counter = 0, tt = 0, ones = 0.
REQ-015 CAPTURE: x0..x6 = i for exactly SETTLE+1 consecutive cycles per vector.
REQ-016 The wait counter counts 0..SETTLE; on the edge where it equals SETTLE, tt[i] <= f_in and ones <= ones + f_in.
REQ-017 On that same edge, if i < 127 then i <= i+1 and the counter <= 0; if i = 127 then the next state is DONE.
REQ-018 Latency: tt_valid SHALL first be high 128*(SETTLE+1) cycles after the edge that accepted start (256 cycles for SETTLE = 1).
REQ-019 DONE: tt_valid = 1, busy = 0, x0..x6 = 0; tt and ones are held stable while tt_ready = 0.
REQ-020 DONE with tt_ready = 1 -> IDLE; tt_valid is low in the following cycle.
REQ-021 tt and ones keep their last value in IDLE until the next start is accepted.
REQ-022 start is ignored in CAPTURE and DONE, including the handshake cycle; it is never queued.
REQ-023 The ones accumulator SHALL be 8 bits and SHALL NOT overflow; a constant-1 function yields exactly 128.
REQ-024 f_in is sampled only on sample edges; its value in any other cycle has no effect.

Reset
REQ-025 rst_n = 0 at a clock edge -> state IDLE, i = 0, counter = 0, tt = 0, ones = 0, busy = 0, tt_valid = 0, x0..x6 = 0.
REQ-026 Reset applied during CAPTURE or DONE aborts the operation; no partial tt_valid is produced.
REQ-027 rst_n has priority over start and tt_ready in the same cycle.
REQ-028 After rst_n is released, start is accepted on the first edge at which it is high.

Verification
REQ-029 f_in = 0, SETTLE = 1, start pulse -> tt_valid rises 256 cycles after the start edge; tt = 0, ones = 0.
REQ-030 f_in = x0 -> tt = 128'hAAAA_..._AAAA, ones = 64; with f_in = x6 -> tt = {64{1'b1}, 64{1'b0}}, ones = 64.
REQ-031 f_in = AND of x0..x6 -> tt = 1 << 127, ones = 1; f_in = 1 -> tt = all ones, ones = 128.
REQ-032 SETTLE = 3, f_in = x0 registered with 2 cycles delay -> tt still 128'hAAAA..., and tt_valid rises at cycle 512.
REQ-033 tt_ready low for 10 cycles in DONE, with start pulses -> tt_valid, tt and ones stable; IDLE one cycle after tt_ready = 1; start not taken.
REQ-034 rst_n = 0 at vector i = 40 -> all outputs 0 next cycle; a fresh start then gives a correct full capture.
